// File: rtl/fp_prenorm_pipe.sv
// Two-stage pre-normaliser for the FP add/sub datapath: stage 1 orders the operands by
// magnitude, stage 2 aligns the smaller significand with exact guard/round/sticky bits.
module fp_prenorm_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic             sign_A,
   input  logic [EXP_W-1:0] exp_A,
   input  logic [MAN_W-1:0] mant_A,
   input  logic             sign_B,
   input  logic [EXP_W-1:0] exp_B,
   input  logic [MAN_W-1:0] mant_B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign_L,
   output logic [MAN_W:0]   mant_L,
   output logic [MAN_W:0]   mant_S,
   output logic [EXP_W-1:0] exp,
   output logic [2:0]       GRS,
   output logic             shift_flag,
   output logic             swap,
   output logic             eff_sub,
   output logic             special
);

   localparam int          EXT_W = MAN_W + 4;
   localparam int          SH_W  = $clog2(EXT_W);
   localparam logic [31:0] SAT   = 32'(MAN_W + 3);

   logic en1, en2, v1;

   assign en2      = !out_valid || out_ready;
   assign en1      = !v1 || en2;
   assign in_ready = en1 && !rst;

   // Stage 1: unpack and magnitude compare
   logic             hid_a, hid_b, swap_c, eff_sign_b;
   logic [EXP_W-1:0] eexp_a, eexp_b, eexp_l, eexp_s;

   assign hid_a      = |exp_A;
   assign hid_b      = |exp_B;
   assign eexp_a     = hid_a ? exp_A : EXP_W'(1);
   assign eexp_b     = hid_b ? exp_B : EXP_W'(1);
   assign eff_sign_b = sign_B ^ op_sub;
   assign swap_c     = {eexp_b, hid_b, mant_B} > {eexp_a, hid_a, mant_A};
   assign eexp_l     = swap_c ? eexp_b : eexp_a;
   assign eexp_s     = swap_c ? eexp_a : eexp_b;

   logic             s1_sign, s1_hid_l, s1_hid_s, s1_swap, s1_eff_sub, s1_special;
   logic [EXP_W-1:0] s1_exp, s1_diff;
   logic [MAN_W-1:0] s1_mant_l, s1_mant_s;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1         <= 1'b0;
         s1_sign    <= 1'b0;
         s1_hid_l   <= 1'b0;
         s1_hid_s   <= 1'b0;
         s1_swap    <= 1'b0;
         s1_eff_sub <= 1'b0;
         s1_special <= 1'b0;
         s1_exp     <= '0;
         s1_diff    <= '0;
         s1_mant_l  <= '0;
         s1_mant_s  <= '0;
      end else if (en1) begin
         v1 <= in_valid;
         if (in_valid) begin
            s1_sign    <= swap_c ? eff_sign_b : sign_A;
            s1_hid_l   <= swap_c ? hid_b : hid_a;
            s1_hid_s   <= swap_c ? hid_a : hid_b;
            s1_mant_l  <= swap_c ? mant_B : mant_A;
            s1_mant_s  <= swap_c ? mant_A : mant_B;
            s1_exp     <= eexp_l;
            s1_diff    <= eexp_l - eexp_s;
            s1_swap    <= swap_c;
            s1_eff_sub <= sign_A ^ sign_B ^ op_sub;
            s1_special <= (&exp_A) | (&exp_B);
         end
      end
   end

   // Stage 2: saturating alignment shift; sticky also collects bits pushed past R
   logic [SH_W-1:0]  sh;
   logic [EXT_W-1:0] ext, shifted, lost;
   logic [2:0]       grs_c;

   // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
   always_comb begin
      sh      = (32'(s1_diff) > SAT) ? SH_W'(SAT) : SH_W'(s1_diff);
      ext     = {s1_hid_s, s1_mant_s, 3'b000};
      shifted = ext >> sh;
      lost    = ext & ~({EXT_W{1'b1}} << sh);
      grs_c   = {shifted[2], shifted[1], shifted[0] | (|lost)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         sign_L     <= 1'b0;
         mant_L     <= '0;
         mant_S     <= '0;
         exp        <= '0;
         GRS        <= '0;
         shift_flag <= 1'b0;
         swap       <= 1'b0;
         eff_sub    <= 1'b0;
         special    <= 1'b0;
      end else if (en2) begin
         out_valid <= v1;
         if (v1) begin
            sign_L     <= s1_sign;
            mant_L     <= {s1_hid_l, s1_mant_l};
            mant_S     <= shifted[EXT_W-1:3];
            exp        <= s1_exp;
            GRS        <= grs_c;
            shift_flag <= |s1_diff;
            swap       <= s1_swap;
            eff_sub    <= s1_eff_sub;
            special    <= s1_special;
         end
      end
   end

endmodule
